mm_block_read_sequencer: RTL and testbench

- Read-side controller for the ping-pong matrix-multiply buffer.
- Generates the per-block A/B BRAM read address stream (rd_addr_A, rd_addr_B) for the output-stationary systolic array, with accumulate-first/last markers.
- Pulses done_read_control at the end of each B block, and done_multiply after the last block has drained.
- Sits in the fast-clock domain between the buffer's start handshake and the array.

---
 rtl/mm_ctrl_pkg.sv | 16 +
 rtl/nested_loop_cnt.sv | 52 +++++
 rtl/mm_block_read_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_mm_block_read_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_ctrl_pkg.sv
// Shared types for the matrix-multiply read-side control.
// Combinational definitions only; no latency, no flow control.
package mm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    READ,
    BLK_DONE,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int DRAIN_CNT_W = 8;

endpackage

// File: rtl/nested_loop_cnt.sv
// Three-level i/j/k loop counter (k innermost); advances one step per enabled cycle.
// Flags are combinational from the current position; i_en low freezes every level.
module nested_loop_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_bnd_i,
  input  logic [W-1:0] i_bnd_j,
  input  logic [W-1:0] i_bnd_k,
  output logic [W-1:0] o_k,
  output logic         o_k_wrap,
  output logic         o_j_wrap,
  output logic         o_last
);

  logic [W-1:0] r_i;
  logic [W-1:0] r_j;
  logic [W-1:0] r_k;

  assign o_k      = r_k;
  assign o_k_wrap = (r_k == i_bnd_k - W'(1));
  assign o_j_wrap = o_k_wrap && (r_j == i_bnd_j - W'(1));
  assign o_last   = o_j_wrap && (r_i == i_bnd_i - W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_en) begin
      if (o_k_wrap) begin
        r_k <= '0;
        if (o_j_wrap) begin
          r_j <= '0;
          r_i <= o_last ? '0 : r_i + W'(1);
        end else begin
          r_j <= r_j + W'(1);
        end
      end else begin
        r_k <= r_k + W'(1);
      end
    end
  end

endmodule

// File: rtl/mm_block_read_sequencer.sv
// Per-block A/B read address sequencer for the output-stationary array; outputs registered, first read one cycle after start_block.
// hold stalls the read stream in place; block and job completion are one-cycle pulses.
module mm_block_read_sequencer
  import mm_ctrl_pkg::*;
#(
  parameter int ADDR_W_A     = 12,
  parameter int ADDR_W_B     = 12,
  parameter int MATRIXSIZE_W = 16,
  parameter int DRAIN_LAT    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_multiply,
  input  logic                    start_block,
  input  logic                    hold,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M1dN1,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2,
  input  logic [MATRIXSIZE_W-1:0] BLOCKS,
  output logic                    rd_en,
  output logic [ADDR_W_A-1:0]     rd_addr_A,
  output logic [ADDR_W_B-1:0]     rd_addr_B,
  output logic                    acc_first,
  output logic                    acc_last,
  output logic                    done_read_control,
  output logic                    done_multiply,
  output logic                    busy
);

  localparam logic [DRAIN_CNT_W-1:0] L_DRAIN_END = DRAIN_CNT_W'(DRAIN_LAT - 1);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [MATRIXSIZE_W-1:0] r_m2;
  logic [MATRIXSIZE_W-1:0] r_m1dn1;
  logic [MATRIXSIZE_W-1:0] r_bwdn2;
  logic [MATRIXSIZE_W-1:0] r_blocks;
  logic                    r_degen;
  logic [MATRIXSIZE_W-1:0] r_blk_cnt;
  logic [MATRIXSIZE_W-1:0] w_blk_nxt;
  logic [DRAIN_CNT_W-1:0]  r_drain_cnt;
  logic [ADDR_W_A-1:0]     r_a_base;
  logic [ADDR_W_B-1:0]     r_b_base;

  logic                    r_rd_en;
  logic [ADDR_W_A-1:0]     r_rd_addr_A;
  logic [ADDR_W_B-1:0]     r_rd_addr_B;
  logic                    r_acc_first;
  logic                    r_acc_last;
  logic                    r_drc;
  logic                    r_dm;
  logic                    r_dm_fired;

  logic                    w_issue;
  logic                    w_cnt_clr;
  logic [MATRIXSIZE_W-1:0] w_k;
  logic                    w_k_wrap;
  logic                    w_j_wrap;
  logic                    w_last;

  assign w_blk_nxt = r_blk_cnt + MATRIXSIZE_W'(1);
  assign w_cnt_clr = (r_state == IDLE) || (r_state == BLK_DONE);

  nested_loop_cnt #(
    .W(MATRIXSIZE_W)
  ) u_loop (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_issue),
    .i_bnd_i  (r_m1dn1),
    .i_bnd_j  (r_bwdn2),
    .i_bnd_k  (r_m2),
    .o_k      (w_k),
    .o_k_wrap (w_k_wrap),
    .o_j_wrap (w_j_wrap),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The first read of a block issues straight out of WAIT_BLK so it lands the cycle after start_block.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_multiply) w_state_nxt = WAIT_BLK;
      end
      WAIT_BLK: begin
        if (!start_multiply) begin
          w_state_nxt = IDLE;
        end else if (r_degen) begin
          w_state_nxt = DRAIN;
        end else if (start_block) begin
          w_issue     = 1'b1;
          w_state_nxt = w_last ? BLK_DONE : READ;
        end
      end
      READ: begin
        if (!hold) begin
          w_issue = 1'b1;
          if (w_last) w_state_nxt = BLK_DONE;
        end
      end
      BLK_DONE: begin
        w_state_nxt = (w_blk_nxt >= r_blocks) ? DRAIN : WAIT_BLK;
      end
      DRAIN: begin
        if (r_drain_cnt == L_DRAIN_END) w_state_nxt = DONE;
      end
      DONE: begin
        if (!start_multiply) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m2     <= '0;
      r_m1dn1  <= '0;
      r_bwdn2  <= '0;
      r_blocks <= '0;
      r_degen  <= 1'b0;
    end else if ((r_state == IDLE) && start_multiply) begin
      r_m2     <= M2;
      r_m1dn1  <= M1dN1;
      r_bwdn2  <= BLOCK_WIDTHdN2;
      r_blocks <= (BLOCKS == '0) ? MATRIXSIZE_W'(1) : BLOCKS;
      r_degen  <= (M2 == '0) || (M1dN1 == '0) || (BLOCK_WIDTHdN2 == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blk_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_blk_cnt <= '0;
      end else if (r_state == BLK_DONE) begin
        r_blk_cnt <= w_blk_nxt;
      end
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRAIN_CNT_W'(1) : '0;
    end
  end

  // b_base steps by M2 per j and restarts with each new row i; a_base steps by M2 per i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_base <= '0;
      r_b_base <= '0;
    end else if (w_cnt_clr) begin
      r_a_base <= '0;
      r_b_base <= '0;
    end else if (w_issue) begin
      if (w_j_wrap) begin
        r_a_base <= r_a_base + ADDR_W_A'(r_m2);
        r_b_base <= '0;
      end else if (w_k_wrap) begin
        r_b_base <= r_b_base + ADDR_W_B'(r_m2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_en     <= 1'b0;
      r_rd_addr_A <= '0;
      r_rd_addr_B <= '0;
      r_acc_first <= 1'b0;
      r_acc_last  <= 1'b0;
      r_drc       <= 1'b0;
      r_dm        <= 1'b0;
      r_dm_fired  <= 1'b0;
    end else begin
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_rd_addr_A <= r_a_base + ADDR_W_A'(w_k);
        r_rd_addr_B <= r_b_base + ADDR_W_B'(w_k);
        r_acc_first <= (w_k == '0);
        r_acc_last  <= w_k_wrap;
      end else begin
        r_acc_first <= 1'b0;
        r_acc_last  <= 1'b0;
      end
      r_drc      <= (r_state == BLK_DONE);
      r_dm       <= (r_state == DONE) && !r_dm_fired;
      r_dm_fired <= (r_state == DONE);
    end
  end

  assign rd_en             = r_rd_en;
  assign rd_addr_A         = r_rd_addr_A;
  assign rd_addr_B         = r_rd_addr_B;
  assign acc_first         = r_acc_first;
  assign acc_last          = r_acc_last;
  assign done_read_control = r_drc;
  assign done_multiply     = r_dm;
  assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_mm_block_read_sequencer.sv
// Bench for mm_block_read_sequencer: table of jobs checked against a read-stream scoreboard,
// plus hand-written abort and mid-block reset sequences.
module tb_mm_block_read_sequencer;

  localparam int DL   = 8;
  localparam int AMSK = 4095;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_multiply = 1'b0;
  logic        start_block = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] M2 = '0;
  logic [15:0] M1dN1 = '0;
  logic [15:0] BLOCK_WIDTHdN2 = '0;
  logic [15:0] BLOCKS = '0;
  logic        rd_en;
  logic [11:0] rd_addr_A;
  logic [11:0] rd_addr_B;
  logic        acc_first;
  logic        acc_last;
  logic        done_read_control;
  logic        done_multiply;
  logic        busy;

  mm_block_read_sequencer #(
    .ADDR_W_A(12), .ADDR_W_B(12), .MATRIXSIZE_W(16), .DRAIN_LAT(DL)
  ) dut (
    .clk(clk), .rst(rst), .start_multiply(start_multiply), .start_block(start_block),
    .hold(hold), .M2(M2), .M1dN1(M1dN1), .BLOCK_WIDTHdN2(BLOCK_WIDTHdN2), .BLOCKS(BLOCKS),
    .rd_en(rd_en), .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B), .acc_first(acc_first),
    .acc_last(acc_last), .done_read_control(done_read_control), .done_multiply(done_multiply),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m1; int bw; int m2; int blocks;
    int hold_at; int hold_len;
    int exp_reads; int exp_drc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0, drc_cnt = 0, dm_cnt = 0;
  int last_rd_cyc = 0, drc_cyc = 0, dm_cyc = 0;
  int sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pack_rd(int a, int b, int f, int l);
    return ((a & AMSK) << 14) | ((b & AMSK) << 2) | (f << 1) | l;
  endfunction

  // Reference read stream for one block, written with direct multiplication.
  task automatic push_block(input int m1, input int bw, input int m2);
    for (int i = 0; i < m1; i++)
      for (int j = 0; j < bw; j++)
        for (int k = 0; k < m2; k++)
          sb.push_back(pack_rd(i * m2 + k, j * m2 + k, int'(k == 0), int'(k == m2 - 1)));
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      if (rd_en) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_rd", 1, 0);
        end else begin
          chk("rd_dat", pack_rd(int'(rd_addr_A), int'(rd_addr_B), int'(acc_first), int'(acc_last)),
              sb.pop_front());
        end
      end
      if (done_read_control) begin drc_cnt++; drc_cyc = cyc; end
      if (done_multiply) begin dm_cnt++; dm_cyc = cyc; end
    end
  end

  task automatic run_vec(input vec_t v);
    int blks, per_blk, rd0, drc0, dm0, c0, cs, t, lim;
    bit degen;
    blks    = (v.blocks == 0) ? 1 : v.blocks;
    per_blk = v.m1 * v.bw * v.m2;
    degen   = (v.m1 == 0) || (v.bw == 0) || (v.m2 == 0);
    rd0 = rd_cnt; drc0 = drc_cnt; dm0 = dm_cnt;
    @(negedge clk);
    M1dN1 = 16'(v.m1); BLOCK_WIDTHdN2 = 16'(v.bw); M2 = 16'(v.m2); BLOCKS = 16'(v.blocks);
    start_multiply = 1'b1;
    c0 = cyc;
    @(negedge clk);
    M1dN1 = '0; BLOCK_WIDTHdN2 = '0; M2 = '0; BLOCKS = '0;
    if (!degen) begin
      for (int b = 0; b < blks; b++) begin
        start_block = 1'b1;
        push_block(v.m1, v.bw, v.m2);
        cs = cyc;
        @(negedge clk);
        start_block = 1'b0;
        chk("first_rd", int'(rd_en), 1);
        t = 1;
        lim = per_blk + v.hold_len + 20;
        while (drc_cnt == drc0 + b && t < lim) begin
          hold = (t >= v.hold_at) && (t < v.hold_at + v.hold_len);
          @(negedge clk);
          t++;
        end
        hold = 1'b0;
        chk("drc_seen", drc_cnt - drc0, b + 1);
        chk("drc_timing", drc_cyc - last_rd_cyc, 1);
        chk("rd_span", last_rd_cyc - cs, per_blk + v.hold_len);
        if (b < blks - 1) repeat (5) @(negedge clk);
      end
    end
    t = 0;
    while (dm_cnt == dm0 && t < DL + 40) begin
      @(negedge clk);
      t++;
    end
    chk("dm_seen", dm_cnt - dm0, 1);
    if (degen) chk("dm_timing_degen", dm_cyc - c0, DL + 3);
    else       chk("dm_timing", dm_cyc - drc_cyc, DL + 1);
    // start_multiply is still high: no restart, no second pulse.
    repeat (10) @(negedge clk);
    chk("busy_in_done", int'(busy), 1);
    chk("dm_count", dm_cnt - dm0, 1);
    chk("rd_count", rd_cnt - rd0, v.exp_reads);
    chk("drc_count", drc_cnt - drc0, v.exp_drc);
    chk("sb_empty", sb.size(), 0);
    start_multiply = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_after_drop", int'(busy), 0);
  endtask

  vec_t vecs[8];

  initial begin
    int rd0, drc0, dm0, t;
    vecs[0] = '{2, 2, 3,    1, 0, 0, 12,    1};
    vecs[1] = '{2, 2, 3,    3, 0, 0, 36,    3};
    vecs[2] = '{2, 2, 3,    1, 3, 3, 12,    1};
    vecs[3] = '{2, 2, 0,    1, 0, 0, 0,     0};
    vecs[4] = '{0, 2, 3,    2, 0, 0, 0,     0};
    vecs[5] = '{1, 1, 1,    0, 0, 0, 1,     1};
    vecs[6] = '{1, 1, 4,    1, 3, 2, 4,     1};
    vecs[7] = '{3, 3, 1400, 1, 0, 0, 12600, 1};

    repeat (3) @(negedge clk);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drc", int'(done_read_control), 0);
    chk("rst_dm", int'(done_multiply), 0);
    chk("rst_addr", int'({rd_addr_A, rd_addr_B}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 8; n++) run_vec(vecs[n]);

    // Abort while waiting for a block.
    rd0 = rd_cnt; drc0 = drc_cnt; dm0 = dm_cnt;
    M1dN1 = 16'd2; BLOCK_WIDTHdN2 = 16'd2; M2 = 16'd3; BLOCKS = 16'd1;
    start_multiply = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy_wait", int'(busy), 1);
    start_multiply = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    repeat (DL + 5) @(negedge clk);
    chk("abort_no_pulses", (rd_cnt - rd0) + (drc_cnt - drc0) + (dm_cnt - dm0), 0);

    // Asynchronous reset after five reads of a block.
    drc0 = drc_cnt; dm0 = dm_cnt; rd0 = rd_cnt;
    start_multiply = 1'b1;
    @(negedge clk);
    start_block = 1'b1;
    push_block(2, 2, 3);
    @(negedge clk);
    start_block = 1'b0;
    t = 0;
    while (rd_cnt - rd0 < 5 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reads", rd_cnt - rd0, 5);
    chk("rst_mid_pre_addr", int'({rd_addr_A, rd_addr_B}), int'({12'd1, 12'd4}));
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_rd_en", int'(rd_en), 0);
    chk("rst_mid_addr", int'({rd_addr_A, rd_addr_B}), 0);
    chk("rst_mid_acc", int'({acc_first, acc_last}), 0);
    chk("rst_mid_busy", int'(busy), 0);
    sb.delete();
    start_multiply = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (DL + 5) @(negedge clk);
    chk("rst_mid_no_pulses", (drc_cnt - drc0) + (dm_cnt - dm0), 0);

    // Fresh job after reset restarts at A=0, B=0.
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
